pipe_skid_fifo: RTL and testbench
=================================

# pipe_skid_fifo

Parametrised elastic buffer for DMA datapaths with valid/ready handshakes on both sides, DATA_W-bit payload, and DEPTH entries of storage. It is the successor to the two-entry pipeline skid buffer. It keeps fully registered o_ready and o_valid, so there is no combinational path between i_ready and o_ready. It adds configurable depth, an occupancy output, and an optional synchronous flush. It sits between DMA read-response and write-request stages to absorb backpressure bubbles at full throughput.

## Interface
- DATA_W, 32, payload width in bits (>=1)
- DEPTH, 2, number of storage entries (>=2; need not be a power of two)
- CNT_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- i_data  in  DATA_W  upstream payload
- i_valid  in  1  upstream valid
- o_ready  out  1  upstream ready (flop output)
- o_data  out  DATA_W  downstream payload
- o_valid  out  1  downstream valid (derived from flops only)
- i_ready  in  1  downstream ready
- o_count  out  CNT_W  current occupancy
- i_flush  in  1  synchronous flush (present only with PIPE_SKID_FIFO_FLUSH_EN)

## Operation
- Storage: circular array mem[DEPTH], wr_ptr, rd_ptr in 0..DEPTH-1, count in 0..DEPTH.
- push = i_valid && o_ready; pop = o_valid && i_ready.
- On push: mem[wr_ptr] <= i_data; wr_ptr advances, wrapping DEPTH-1 -> 0.
- On pop: rd_ptr advances with the same wrap.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged and is legal at any occupancy except full, where push cannot occur.
- o_valid = (count != 0); o_data = mem[rd_ptr]; o_count = count.
- o_ready register <= (count_next < DEPTH). It is never computed from i_ready in the same cycle.
- Full (count == DEPTH): o_ready = 0. Upstream data is held by the upstream source; none is dropped.
- Empty (count == 0): o_valid = 0. o_data is don't-care.
- While o_valid && !i_ready: o_data and o_valid hold stable until pop.
- Data is delivered in strict FIFO order; no reordering, duplication, or loss.
- Reset (async assert, any cycle including mid-transfer):
  - count, wr_ptr, rd_ptr = 0; o_valid = 0; o_ready = 0; o_count = 0.
  - mem contents are not reset.
  - o_ready rises on the first clock edge after rstn deasserts.

## Timing
- Latency: a word pushed at edge t into an empty buffer is visible (o_valid = 1) from edge t, i.e. one cycle after it was presented.
- Throughput: one word per cycle sustained when i_ready = 1 continuously.
- o_ready deasserts on the edge where count reaches DEPTH. It reasserts on the edge after the first pop from full.
- One-cycle backpressure (i_ready low for one cycle) with DEPTH >= 2 does not deassert o_ready unless occupancy reaches DEPTH.
- i_valid may assert or deassert at any cycle. Upstream must hold i_data/i_valid while !o_ready per handshake rules. The block does not check this.

## Configuration
- PIPE_SKID_FIFO_FLUSH_EN defined:
  - i_flush port exists.
  - i_flush = 1 at an edge forces count, wr_ptr and rd_ptr to 0, o_valid = 0 next cycle, and o_ready = 1 next cycle.
  - Any push or pop in the flush cycle is discarded; flush has priority.
- PIPE_SKID_FIFO_FLUSH_EN undefined:
  - No i_flush port.
  - State is cleared only by rstn.

## Test plan
- Reset release, DEPTH=2: rstn low with i_valid=1 -> o_valid=0, o_ready=0, o_count=0; one edge after release o_ready=1.
- Streaming, DEPTH=4: push 0x00..0x0F with i_ready=1 every cycle -> output 0x00..0x0F in order, one per cycle, o_count stays 1, o_ready never drops.
- Fill/drain, DEPTH=3 (non-power-of-two wrap): i_ready=0, push 0xA1,0xA2,0xA3 -> o_ready=0 after third edge, o_count=3. Raise i_ready -> output A1,A2,A3; o_ready=1 the edge after the first pop. Repeat 4 times to exercise pointer wrap.
- Simultaneous push/pop at count=DEPTH-1 (DEPTH=4): o_count stays 3 and o_ready stays 1 across 10 cycles of both handshakes.
- Random i_valid/i_ready at 50% each, DEPTH=5, 10000 words -> scoreboard exact order match, o_count never exceeds 5, o_data stable while o_valid && !i_ready.
- With PIPE_SKID_FIFO_FLUSH_EN, DEPTH=4: load 3 words, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_count=0, o_ready=1, flushed-cycle word absent from the output.

Source files
------------

// File: rtl/pipe_skid_fifo.sv
// Elastic valid/ready FIFO with registered o_ready; successor to the two-entry skid buffer.
// Optional synchronous flush enabled by defining PIPE_SKID_FIFO_FLUSH_EN.
module pipe_skid_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_count
`ifdef PIPE_SKID_FIFO_FLUSH_EN
  ,
  input  logic              i_flush
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;
  logic              flush;

`ifdef PIPE_SKID_FIFO_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // o_valid comes only from the count flop, so pop never depends on i_valid.
  assign o_valid = (count != '0);
  assign o_data  = mem[rd_ptr];
  assign o_count = count;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_ready <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      o_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      count   <= count_next;
      // Registered from next occupancy only; no path from i_ready to o_ready this cycle.
      o_ready <= (count_next < FULL_CNT);
    end
  end

  // NOTE: storage has no reset; count gates o_valid so stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: tb/tb_pipe_skid_fifo.sv
// Self-checking bench for pipe_skid_fifo at DEPTH=3 (non-power-of-two wrap).
// Flush checks are compiled in when PIPE_SKID_FIFO_FLUSH_EN is defined.
module tb_pipe_skid_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic [CNT_W-1:0]  o_count;
`ifdef PIPE_SKID_FIFO_FLUSH_EN
  logic              i_flush;
`endif

  int total = 0;
  int bad   = 0;

  pipe_skid_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_count (o_count)
`ifdef PIPE_SKID_FIFO_FLUSH_EN
    ,
    .i_flush (i_flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ir;
    logic [31:0] d;
    logic        ev;
    logic        er;
    int          ec;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    rstn    = 1'b0;
    #7;
    rstn    = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] next_word;
    int          m_count;
    logic        m_ready;
    logic        m_push;
    logic        m_pop;

    // state 0/ready 1 entering the table; A4 is refused while full.
    tbl[0]  = '{1'b1, 1'b0, 32'hA1, 1'b1, 1'b1, 1, 32'hA1};
    tbl[1]  = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b1, 2, 32'hA1};
    tbl[2]  = '{1'b1, 1'b0, 32'hA3, 1'b1, 1'b0, 3, 32'hA1};
    tbl[3]  = '{1'b1, 1'b0, 32'hA4, 1'b1, 1'b0, 3, 32'hA1};
    tbl[4]  = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 2, 32'hA2};
    tbl[5]  = '{1'b1, 1'b1, 32'hA4, 1'b1, 1'b1, 2, 32'hA3};
    tbl[6]  = '{1'b1, 1'b1, 32'hA5, 1'b1, 1'b1, 2, 32'hA4};
    tbl[7]  = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 1, 32'hA5};
    tbl[8]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 0, 32'h00};
    tbl[9]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 0, 32'h00};
    tbl[10] = '{1'b1, 1'b1, 32'hB1, 1'b1, 1'b1, 1, 32'hB1};

`ifdef PIPE_SKID_FIFO_FLUSH_EN
    i_flush = 1'b0;
`endif

    // Reset held with i_valid high: nothing may be accepted.
    rstn    = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b0;
    i_data  = 32'hDEAD;
    step();
    step();
    check("rst_valid", 32'(o_valid), 0);
    check("rst_ready", 32'(o_ready), 0);
    check("rst_count", 32'(o_count), 0);
    #3;
    rstn = 1'b1;
    #1;
    check("rel_ready_pre_edge", 32'(o_ready), 0);
    step();
    check("rel_ready", 32'(o_ready), 1);
    check("rel_count", 32'(o_count), 0);
    i_valid = 1'b0;

    // Table-driven fill / full / drain / wrap.
    for (int i = 0; i < 11; i++) begin
      i_valid = tbl[i].iv;
      i_ready = tbl[i].ir;
      i_data  = tbl[i].d;
      step();
      check($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].er));
      check($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].ec));
      if (tbl[i].ev) check($sformatf("tbl%0d_data", i), o_data, tbl[i].ed);
    end

    // Streaming: count stays 1, one word per cycle in order.
    for (int k = 0; k < 16; k++) begin
      i_valid = 1'b1;
      i_ready = 1'b1;
      i_data  = 32'(k);
      step();
      check($sformatf("stream%0d_data", k), o_data, 32'(k));
      check($sformatf("stream%0d_count", k), 32'(o_count), 1);
      check($sformatf("stream%0d_ready", k), 32'(o_ready), 1);
    end
    i_valid = 1'b0;
    step();
    check("stream_drained", 32'(o_count), 0);

    // Repeated fill to full then drain, wrapping the pointers several times.
    for (int r = 0; r < 4; r++) begin
      i_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        i_valid = 1'b1;
        i_data  = 32'hC0 + 32'(r * 16 + k);
        step();
      end
      i_valid = 1'b0;
      check($sformatf("fill%0d_ready", r), 32'(o_ready), 0);
      check($sformatf("fill%0d_count", r), 32'(o_count), DEPTH);
      i_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        check($sformatf("drain%0d_%0d", r, k), o_data, 32'hC0 + 32'(r * 16 + k));
        step();
        check($sformatf("drain%0d_%0d_ready", r, k), 32'(o_ready), 1);
      end
      check($sformatf("drain%0d_empty", r), 32'(o_valid), 0);
    end

    // Simultaneous push/pop at count = DEPTH-1.
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      i_valid = 1'b1;
      i_data  = 32'h100 + 32'(k);
      step();
    end
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1;
      i_ready = 1'b1;
      i_data  = 32'h100 + 32'(k + DEPTH - 1);
      step();
      check($sformatf("pp%0d_count", k), 32'(o_count), DEPTH - 1);
      check($sformatf("pp%0d_ready", k), 32'(o_ready), 1);
      check($sformatf("pp%0d_data", k), o_data, 32'h100 + 32'(k + 1));
    end

    // Asynchronous reset mid-transfer takes effect before any edge.
    i_valid = 1'b0;
    i_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_ready", 32'(o_ready), 0);
    check("midrst_count", 32'(o_count), 0);
    #3;
    rstn = 1'b1;
    step();
    check("midrst_rel_ready", 32'(o_ready), 1);

`ifdef PIPE_SKID_FIFO_FLUSH_EN
    i_ready = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      i_valid = 1'b1;
      i_data  = 32'h200 + 32'(k);
      step();
    end
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_data  = 32'hEE;
    step();
    i_flush = 1'b0;
    check("flush_valid", 32'(o_valid), 0);
    check("flush_count", 32'(o_count), 0);
    check("flush_ready", 32'(o_ready), 1);
    i_valid = 1'b1;
    i_ready = 1'b0;
    i_data  = 32'h55;
    step();
    i_valid = 1'b0;
    check("postflush_data", o_data, 32'h55);
    check("postflush_count", 32'(o_count), 1);
    do_reset();
`endif

    // Random valid/ready against a queue-based reference model.
    do_reset();
    q.delete();
    m_count   = 0;
    m_ready   = 1'b1;
    next_word = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      i_data  = next_word;
      m_push  = i_valid && m_ready;
      m_pop   = (m_count != 0) && i_ready;
      step();
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        q.push_back(next_word);
        next_word++;
      end
      m_count = m_count + int'(m_push) - int'(m_pop);
      m_ready = (m_count < DEPTH);
      check("rnd_count", 32'(o_count), 32'(m_count));
      check("rnd_ready", 32'(o_ready), 32'(m_ready));
      check("rnd_valid", 32'(o_valid), 32'(m_count != 0));
      if (m_count != 0) check("rnd_data", o_data, q[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
